// File: rtl/boa_pwr_seq.sv
// boa_pwr_seq: power/reset sequencer between the PMU, the board reset button
// and the CPU subsystem.
// - Debounces the raw button and arbitrates button presses, PMU reset requests
//   and PMU shutdown requests.
// - Drives core reset and core shutdown (clock gate) controls.
// - Records the cause of the most recent reset.
//
// Ports
//   clk          in   system clock; must keep running during shutdown
//   rst_n        in   synchronous reset, active low
//   btn_raw      in   raw reset button, asynchronous, active high
//   pmu_rst_req  in   PMU reset request, level
//   pmu_shdn_req in   PMU shutdown request, level
//   core_rst     out  reset to the CPU subsystem, active high
//   core_shdn    out  shutdown; the top level ORs this into the core clock gate
//   state        out  0 HOLD, 1 RUN, 2 SHDN
//   rst_cause    out  0 POR, 1 BTN, 2 SW, 3 WAKE
//
// State | meaning
// HOLD  | core held in reset for RST_HOLD cycles; press/pmu_rst_req restart it
// RUN   | core running; press > pmu_rst_req > pmu_shdn_req
// SHDN  | core clock gated; press (if WAKE_ON_BTN) or pmu_rst_req wakes it
module boa_pwr_seq #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int RST_HOLD        = 16,
    parameter int WAKE_ON_BTN     = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_raw,
    input  logic       pmu_rst_req,
    input  logic       pmu_shdn_req,
    output logic       core_rst,
    output logic       core_shdn,
    output logic [1:0] state,
    output logic [1:0] rst_cause
);

    localparam int HW = $clog2(RST_HOLD + 1);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_RELOAD = HW'(RST_HOLD - 1);
    localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam bit WAKE_EN = (WAKE_ON_BTN != 0);

    localparam logic [1:0] CAUSE_POR  = 2'd0;
    localparam logic [1:0] CAUSE_BTN  = 2'd1;
    localparam logic [1:0] CAUSE_SW   = 2'd2;
    localparam logic [1:0] CAUSE_WAKE = 2'd3;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_RUN  = 2'd1,
        ST_SHDN = 2'd2
    } state_t;

    logic          sync1;
    logic          btn_s;
    logic          deb;
    logic          press;
    logic [DW-1:0] deb_cnt;

    // press is registered alongside deb so it is high exactly on the cycle
    // the debounced level first reads 1; a release never produces an event.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            btn_s   <= 1'b0;
            deb     <= 1'b0;
            deb_cnt <= '0;
            press   <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            btn_s <= sync1;
            press <= 1'b0;
            if (btn_s == deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb     <= btn_s;
                deb_cnt <= '0;
                press   <= btn_s;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    state_t        cur_state;
    state_t        nxt_state;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] nxt_hold;
    logic [1:0]    cause_q;
    logic [1:0]    nxt_cause;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_state <= ST_HOLD;
            hold_cnt  <= HOLD_RELOAD;
            cause_q   <= CAUSE_POR;
        end else begin
            cur_state <= nxt_state;
            hold_cnt  <= nxt_hold;
            cause_q   <= nxt_cause;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        nxt_hold  = hold_cnt;
        nxt_cause = cause_q;
        case (cur_state)
            ST_HOLD: begin
                // A new request while in reset restarts the hold window.
                if (press) begin
                    nxt_hold  = HOLD_RELOAD;
                    nxt_cause = CAUSE_BTN;
                end else if (pmu_rst_req) begin
                    nxt_hold  = HOLD_RELOAD;
                    nxt_cause = CAUSE_SW;
                end else if (hold_cnt == '0) begin
                    nxt_state = ST_RUN;
                end else begin
                    nxt_hold = hold_cnt - 1'b1;
                end
            end
            ST_RUN: begin
                if (press) begin
                    nxt_state = ST_HOLD;
                    nxt_hold  = HOLD_RELOAD;
                    nxt_cause = CAUSE_BTN;
                end else if (pmu_rst_req) begin
                    nxt_state = ST_HOLD;
                    nxt_hold  = HOLD_RELOAD;
                    nxt_cause = CAUSE_SW;
                end else if (pmu_shdn_req) begin
                    nxt_state = ST_SHDN;
                end
            end
            ST_SHDN: begin
                if (press && WAKE_EN) begin
                    nxt_state = ST_HOLD;
                    nxt_hold  = HOLD_RELOAD;
                    nxt_cause = CAUSE_WAKE;
                end else if (pmu_rst_req) begin
                    nxt_state = ST_HOLD;
                    nxt_hold  = HOLD_RELOAD;
                    nxt_cause = CAUSE_SW;
                end
            end
            default: begin
                nxt_state = ST_HOLD;
                nxt_hold  = HOLD_RELOAD;
            end
        endcase
    end

    assign core_rst  = (cur_state == ST_HOLD);
    assign core_shdn = (cur_state == ST_SHDN);
    assign state     = cur_state;
    assign rst_cause = cause_q;

endmodule

// File: tb/tb_boa_pwr_seq.sv
// Testbench for boa_pwr_seq: directed scenarios plus a randomized phase, all
// checked cycle by cycle against a behavioural model of the sequencer.
module tb_boa_pwr_seq;

    localparam int DEB  = 4;
    localparam int HOLD = 3;
    localparam int WAKE = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_raw;
    logic       pmu_rst_req;
    logic       pmu_shdn_req;
    logic       core_rst;
    logic       core_shdn;
    logic [1:0] state;
    logic [1:0] rst_cause;

    int n_cmp = 0;
    int n_err = 0;

    // Model: m_st 0 HOLD / 1 RUN / 2 SHDN; m_left = reset cycles still to show.
    int m_st    = 0;
    int m_left  = HOLD;
    int m_cause = 0;
    int m_s1    = 0;
    int m_bs    = 0;
    int m_deb   = 0;
    int m_run   = 0;
    int m_press = 0;

    boa_pwr_seq #(
        .DEBOUNCE_CYCLES(DEB),
        .RST_HOLD       (HOLD),
        .WAKE_ON_BTN    (WAKE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_raw     (btn_raw),
        .pmu_rst_req (pmu_rst_req),
        .pmu_shdn_req(pmu_shdn_req),
        .core_rst    (core_rst),
        .core_shdn   (core_shdn),
        .state       (state),
        .rst_cause   (rst_cause)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic enter_hold(input int cause);
        m_st    = 0;
        m_left  = HOLD;
        m_cause = cause;
    endtask

    task automatic model_edge(input logic r, input logic b, input logic p, input logic s);
        int accepted;
        if (!r) begin
            m_s1 = 0; m_bs = 0; m_deb = 0; m_run = 0; m_press = 0;
            enter_hold(0);
            return;
        end
        case (m_st)
            0: begin
                if (m_press != 0)  enter_hold(1);
                else if (p)        enter_hold(2);
                else begin
                    m_left--;
                    if (m_left == 0) m_st = 1;
                end
            end
            1: begin
                if (m_press != 0)  enter_hold(1);
                else if (p)        enter_hold(2);
                else if (s)        m_st = 2;
            end
            default: begin
                if (m_press != 0 && WAKE != 0) enter_hold(3);
                else if (p)                    enter_hold(2);
            end
        endcase
        // A new level is accepted after DEB consecutive samples differing from it.
        accepted = 0;
        if (m_bs != m_deb) begin
            m_run++;
            if (m_run == DEB) begin
                m_deb    = m_bs;
                m_run    = 0;
                accepted = 1;
            end
        end else begin
            m_run = 0;
        end
        m_press = (accepted != 0 && m_deb == 1) ? 1 : 0;
        m_bs    = m_s1;
        m_s1    = b ? 1 : 0;
    endtask

    task automatic step(input logic r, input logic b, input logic p, input logic s);
        rst_n        = r;
        btn_raw      = b;
        pmu_rst_req  = p;
        pmu_shdn_req = s;
        @(posedge clk);
        model_edge(r, b, p, s);
        #1;
        check("core_rst",  core_rst,  (m_st == 0) ? 1 : 0);
        check("core_shdn", core_shdn, (m_st == 2) ? 1 : 0);
        check("state",     state,     m_st);
        check("rst_cause", rst_cause, m_cause);
    endtask

    initial begin
        int   n;
        logic btn_lvl;
        int   btn_left;
        logic rn, p, s;

        rst_n = 1'b0; btn_raw = 1'b0; pmu_rst_req = 1'b0; pmu_shdn_req = 1'b0;

        // Reset, then exactly three reset cycles before RUN.
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("por_rst", core_rst, 1);
        check("por_shdn", core_shdn, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("por_still_rst", core_rst, 1);
        step(1, 0, 0, 0);
        check("por_run", state, 1);
        check("por_cause", rst_cause, 0);

        // Button held 10 cycles: one press, HOLD on the 7th edge.
        for (int i = 1; i <= 10; i++) begin
            step(1, 1, 0, 0);
            if (i == 6) check("btn_pre_hold", state, 1);
            if (i == 7) begin
                check("btn_hold", state, 0);
                check("btn_cause", rst_cause, 1);
            end
            if (i == 10) check("btn_back_run", state, 1);
        end
        for (int i = 0; i < 12; i++) step(1, 0, 0, 0);

        // Short glitch: no event, counter cleared.
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0);
        check("glitch_run", state, 1);
        check("glitch_deb_cnt", 32'(dut.deb_cnt), 0);

        // Shutdown, then wake by button.
        step(1, 0, 0, 1);
        check("shdn_state", state, 2);
        check("shdn_out", core_shdn, 1);
        check("shdn_rst", core_rst, 0);
        for (int i = 1; i <= 7; i++) step(1, 1, 0, 0);
        check("wake_state", state, 0);
        check("wake_shdn", core_shdn, 0);
        check("wake_cause", rst_cause, 3);
        for (int i = 0; i < 12; i++) step(1, 0, 0, 0);

        // Reset and shutdown together: reset wins; re-pulse extends the hold.
        n = 0;
        step(1, 0, 1, 1);
        check("sw_state", state, 0);
        check("sw_cause", rst_cause, 2);
        if (core_rst) n++;
        step(1, 0, 1, 0);
        if (core_rst) n++;
        for (int i = 0; i < 20 && core_rst; i++) begin
            step(1, 0, 0, 0);
            if (core_rst) n++;
        end
        check("sw_extend_len", n, 4);
        check("sw_extend_run", state, 1);

        // Press and pmu_rst_req on the same edge: button wins.
        for (int i = 1; i <= 6; i++) step(1, 1, 0, 0);
        step(1, 1, 1, 0);
        check("both_state", state, 0);
        check("both_cause", rst_cause, 1);
        for (int i = 0; i < 12; i++) step(1, 0, 0, 0);

        // rst_n during SHDN.
        step(1, 0, 0, 1);
        check("pre_por_shdn", state, 2);
        step(0, 0, 0, 0);
        check("shdn_por_state", state, 0);
        check("shdn_por_shdn", core_shdn, 0);
        check("shdn_por_cause", rst_cause, 0);

        // Randomized phase.
        btn_lvl  = 1'b0;
        btn_left = 0;
        for (int i = 0; i < 4000; i++) begin
            if (btn_left == 0) begin
                btn_lvl  = 1'($urandom_range(0, 1));
                btn_left = $urandom_range(1, 12);
            end
            btn_left--;
            rn = ($urandom_range(0, 299) != 0);
            p  = ($urandom_range(0, 39) == 0);
            s  = ($urandom_range(0, 24) == 0);
            step(rn, btn_lvl, p, s);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
